// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : baud_tick_gen
// Brief    : Run-time programmable UART baud tick generator. Emits one-cycle
//            rx oversample and tx bit strobes in the clk domain. Defining
//            BAUD_FRAC_EN adds a fractional-divisor accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FRAC_W     = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  logic [DIV_W-1:0]              cfg_div_i,
    input  logic [FRAC_W-1:0]             cfg_frac_i,
    output logic                          cfg_err_o,
    output logic                          rx_tick_o,
    output logic                          tx_tick_o,
    output logic [$clog2(OVERSAMPLE)-1:0] tx_phase_o
);

    localparam int unsigned PHASE_W = $clog2(OVERSAMPLE);
    localparam logic [63:0] c_baud_os = 64'(BAUD) * 64'(OVERSAMPLE);
    localparam logic [DIV_W-1:0] c_div_rst = DIV_W'(64'(CLK_HZ) / c_baud_os);
    localparam logic [PHASE_W-1:0] c_phase_last = PHASE_W'(OVERSAMPLE - 1);

    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_a_q, div_a_d;
    logic [DIV_W-1:0]   div_s_q, div_s_d;
    logic               pend_q, pend_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               rx_tick_q, rx_tick_d;
    logic               tx_tick_q, tx_tick_d;
    logic               cfg_err_q, cfg_err_d;

    logic               w_xfer;
    logic               w_last;
    logic [DIV_W-1:0]   w_period_m1;

`ifdef BAUD_FRAC_EN
    localparam logic [FRAC_W-1:0] c_frac_rst =
        FRAC_W'((64'(CLK_HZ) << FRAC_W) / c_baud_os);

    logic [FRAC_W-1:0]  acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [FRAC_W-1:0]  frac_a_q, frac_a_d;
    logic [FRAC_W-1:0]  frac_s_q, frac_s_d;
    logic [FRAC_W:0]    w_acc_sum;
    logic               w_carry_eff;

    // A carry on an all-ones divisor would need a period of 2^DIV_W; drop it.
    assign w_carry_eff = carry_q && (div_a_q != {DIV_W{1'b1}});
    assign w_period_m1 = w_carry_eff ? div_a_q : (div_a_q - 1'b1);
    assign w_acc_sum   = {1'b0, acc_q} + {1'b0, frac_a_q};
`else
    logic w_unused_frac;

    assign w_unused_frac = ^cfg_frac_i;
    assign w_period_m1   = div_a_q - 1'b1;
`endif

    assign w_xfer = cfg_valid_i && !pend_q;
    assign w_last = (cnt_q == w_period_m1);

    always_comb begin
        cnt_d     = cnt_q;
        div_a_d   = div_a_q;
        div_s_d   = div_s_q;
        pend_d    = pend_q;
        phase_d   = phase_q;
        rx_tick_d = 1'b0;
        tx_tick_d = 1'b0;
        cfg_err_d = 1'b0;
`ifdef BAUD_FRAC_EN
        acc_d     = acc_q;
        carry_d   = carry_q;
        frac_a_d  = frac_a_q;
        frac_s_d  = frac_s_q;
`endif

        if (w_xfer) begin
            if (cfg_div_i >= DIV_W'(2)) begin
                div_s_d = cfg_div_i;
                pend_d  = 1'b1;
`ifdef BAUD_FRAC_EN
                frac_s_d = cfg_frac_i;
`endif
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        if (!en_i) begin
            cnt_d   = '0;
            phase_d = '0;
`ifdef BAUD_FRAC_EN
            acc_d   = '0;
            carry_d = 1'b0;
`endif
            if (pend_q) begin
                div_a_d = div_s_q;
                pend_d  = 1'b0;
`ifdef BAUD_FRAC_EN
                frac_a_d = frac_s_q;
`endif
            end
        end else if (w_last) begin
            cnt_d     = '0;
            rx_tick_d = 1'b1;
            tx_tick_d = (phase_q == c_phase_last);
            phase_d   = phase_q + 1'b1;
`ifdef BAUD_FRAC_EN
            {carry_d, acc_d} = w_acc_sum;
`endif
            // New divisor takes effect on a boundary; phase keeps running.
            if (pend_q) begin
                div_a_d = div_s_q;
                pend_d  = 1'b0;
`ifdef BAUD_FRAC_EN
                frac_a_d = frac_s_q;
                acc_d    = '0;
                carry_d  = 1'b0;
`endif
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            div_a_q   <= c_div_rst;
            div_s_q   <= c_div_rst;
            pend_q    <= 1'b0;
            phase_q   <= '0;
            rx_tick_q <= 1'b0;
            tx_tick_q <= 1'b0;
            cfg_err_q <= 1'b0;
`ifdef BAUD_FRAC_EN
            acc_q     <= '0;
            carry_q   <= 1'b0;
            frac_a_q  <= c_frac_rst;
            frac_s_q  <= c_frac_rst;
`endif
        end else begin
            cnt_q     <= cnt_d;
            div_a_q   <= div_a_d;
            div_s_q   <= div_s_d;
            pend_q    <= pend_d;
            phase_q   <= phase_d;
            rx_tick_q <= rx_tick_d;
            tx_tick_q <= tx_tick_d;
            cfg_err_q <= cfg_err_d;
`ifdef BAUD_FRAC_EN
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            frac_a_q  <= frac_a_d;
            frac_s_q  <= frac_s_d;
`endif
        end
    end

    assign cfg_ready_o = !pend_q;
    assign cfg_err_o   = cfg_err_q;
    assign rx_tick_o   = rx_tick_q;
    assign tx_tick_o   = tx_tick_q;
    assign tx_phase_o  = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_baud_tick_gen
// Brief    : Directed self-checking bench for baud_tick_gen (both builds).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_baud_tick_gen;

`ifdef BAUD_FRAC_EN
    localparam bit c_frac = 1'b1;
`else
    localparam bit c_frac = 1'b0;
`endif
    localparam int c_rst_div = 1302;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        cfg_valid;
    logic [15:0] cfg_div;
    logic [3:0]  cfg_frac;
    logic        cfg_ready;
    logic        cfg_err;
    logic        rx_tick;
    logic        tx_tick;
    logic [2:0]  tx_phase;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    baud_tick_gen dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_div_i   (cfg_div),
        .cfg_frac_i  (cfg_frac),
        .cfg_err_o   (cfg_err),
        .rx_tick_o   (rx_tick),
        .tx_tick_o   (tx_tick),
        .tx_phase_o  (tx_phase)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance until rx_tick is seen high; n counts edges consumed.
    task automatic wait_rx(input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (rx_tick !== 1'b1 && n < budget);
        if (rx_tick !== 1'b1) check("rx_timeout", 32'(rx_tick), 32'd1);
    endtask

    // Offer a divisor while idle; it lands in the active registers one edge later.
    task automatic cfg_idle(input logic [15:0] d, input logic [3:0] f);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_div   = d;
        cfg_frac  = f;
        @(posedge clk);
        #1;
        check("idle_cfg_ready_low", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        cfg_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_cfg_ready_high", 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        int t_tx;
        int p0;
        int exp_p;
        int span;

        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        cfg_frac  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_tick", 32'(rx_tick), 32'd0);
        check("rst_tx_tick", 32'(tx_tick), 32'd0);
        check("rst_tx_phase", 32'(tx_phase), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);

        // Reset-default divisor 1302
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;
        wait_rx(2000, n);
        check("rst_first_period", n, c_rst_div);
        wait_rx(2000, n);
        check("rst_second_period", n, c_rst_div);
        @(negedge clk);
        en = 1'b0;

        // Integer divisor 4: rx every 4, tx every 32
        cfg_idle(16'd4, 4'd0);
        @(negedge clk);
        en = 1'b1;
        wait_rx(100, n);
        check("int_first_period", n, 4);
        check("int_phase_1", 32'(tx_phase), 32'd1);
        t_tx = 0;
        for (int k = 2; k <= 16; k++) begin
            wait_rx(100, n);
            check("int_period", n, 4);
            check("int_phase", 32'(tx_phase), 32'(k % 8));
            check("int_tx_tick", 32'(tx_tick), 32'((k % 8) == 0));
            if (k == 8) t_tx = cyc;
            if (k == 16) check("int_tx_spacing", cyc - t_tx, 32);
        end
        @(negedge clk);
        en = 1'b0;

        // Fractional divisor 4 + 8/16
        cfg_idle(16'd4, 4'd8);
        @(negedge clk);
        en = 1'b1;
        wait_rx(100, n);
        check("frac_first_period", n, 4);
        t0 = cyc;
        for (int k = 2; k <= 17; k++) begin
            wait_rx(100, n);
            exp_p = (c_frac && (k % 2 == 1)) ? 5 : 4;
            check("frac_period", n, exp_p);
        end
        span = cyc - t0;
        check("frac_span16", span, c_frac ? 72 : 64);
        @(negedge clk);
        en = 1'b0;

        // Mid-run reconfiguration 10 -> 3
        cfg_idle(16'd10, 4'd0);
        @(negedge clk);
        en = 1'b1;
        wait_rx(100, n);
        check("mid_first_period", n, 10);
        t0 = cyc;
        p0 = int'(tx_phase);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_div   = 16'd3;
        cfg_frac  = 4'd0;
        @(posedge clk);
        #1;
        check("mid_cfg_ready_low", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_rx(100, n);
        check("mid_old_period", cyc - t0, 10);
        check("mid_phase_a", 32'(tx_phase), 32'((p0 + 1) % 8));
        check("mid_cfg_ready_back", 32'(cfg_ready), 32'd1);
        wait_rx(100, n);
        check("mid_new_period_a", n, 3);
        check("mid_phase_b", 32'(tx_phase), 32'((p0 + 2) % 8));
        wait_rx(100, n);
        check("mid_new_period_b", n, 3);
        t0 = cyc;

        // Illegal offer div=1
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_div   = 16'd1;
        @(posedge clk);
        #1;
        check("ill_cfg_err_pulse", 32'(cfg_err), 32'd1);
        check("ill_cfg_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
        @(posedge clk);
        #1;
        check("ill_cfg_err_clear", 32'(cfg_err), 32'd0);
        wait_rx(100, n);
        check("ill_period", cyc - t0, 3);

        // Reset while pending with tx_phase = 5
        for (int k = 0; k < 16; k++) begin
            if (tx_phase == 3'd5) break;
            wait_rx(100, n);
        end
        check("pre_rst_phase", 32'(tx_phase), 32'd5);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_div   = 16'd50;
        @(posedge clk);
        #1;
        check("pre_rst_pend", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        cfg_valid = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_rx_tick", 32'(rx_tick), 32'd0);
        check("mrst_tx_tick", 32'(tx_tick), 32'd0);
        check("mrst_tx_phase", 32'(tx_phase), 32'd0);
        check("mrst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("mrst_cfg_err", 32'(cfg_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_rx(2000, n);
        check("mrst_default_period", n, c_rst_div);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
